// File: rtl/cdc_hs_tx.sv
// Source-side controller for a 4-phase req/ack clock-domain-crossing handshake.
// Holds the accepted word on dat_o while req_o is up; ack_i is synchronized locally.

module sync #(
   parameter int unsigned STATE      = 2,
   parameter int unsigned DATA_WIDTH = 1
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic [DATA_WIDTH-1:0] d_i,
   output logic [DATA_WIDTH-1:0] q_o
);

   logic [DATA_WIDTH-1:0] stg [STATE];

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int unsigned i = 0; i < STATE; i++) stg[i] <= '0;
      end else begin
         stg[0] <= d_i;
         for (int unsigned i = 1; i < STATE; i++) stg[i] <= stg[i-1];
      end
   end

   assign q_o = stg[STATE-1];

endmodule

module cdc_hs_tx #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned STATE      = 2,
   parameter int unsigned TO_WIDTH   = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  valid_i,
   output logic                  ready_o,
   input  logic [DATA_WIDTH-1:0] dat_i,
   output logic [DATA_WIDTH-1:0] dat_o,
   output logic                  req_o,
   input  logic                  ack_i,
   output logic                  done_o,
   input  logic [TO_WIDTH-1:0]   timeout_i,
   output logic                  timeout_o,
   input  logic                  clr_i
);

   typedef enum logic [1:0] {IDLE, REQ, REL} state_t;

   state_t                state, state_d;
   logic                  ack_s;
   logic                  req_d, done_d, to_d;
   logic [DATA_WIDTH-1:0] dat_d;
   logic [TO_WIDTH-1:0]   cnt, cnt_d;

   sync #(.STATE(STATE), .DATA_WIDTH(1)) u_ack_sync (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .d_i     (ack_i),
      .q_o     (ack_s)
   );

   // A lingering ack from the previous cycle (or after reset) must clear first.
   assign ready_o = (state == IDLE) && !ack_s;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state     <= IDLE;
         req_o     <= 1'b0;
         dat_o     <= '0;
         done_o    <= 1'b0;
         timeout_o <= 1'b0;
         cnt       <= '0;
      end else begin
         state     <= state_d;
         req_o     <= req_d;
         dat_o     <= dat_d;
         done_o    <= done_d;
         timeout_o <= to_d;
         cnt       <= cnt_d;
      end
   end

   always_comb begin
      state_d = state;
      req_d   = req_o;
      dat_d   = dat_o;
      done_d  = 1'b0;
      cnt_d   = '0;
      to_d    = timeout_o;
      if (clr_i) to_d = 1'b0;
      case (state)
         IDLE: begin
            req_d = 1'b0;
            if (valid_i && ready_o) begin
               dat_d   = dat_i;
               req_d   = 1'b1;
               state_d = REQ;
            end
         end
         REQ: begin
            req_d = 1'b1;
            cnt_d = (cnt == '1) ? cnt : cnt + TO_WIDTH'(1);
            // Set is evaluated after clear so a coincident set wins.
            if ((timeout_i != '0) && (cnt == timeout_i - TO_WIDTH'(1))) to_d = 1'b1;
            if (ack_s) begin
               req_d   = 1'b0;
               state_d = REL;
            end
         end
         REL: begin
            req_d = 1'b0;
            if (!ack_s) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            req_d   = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_cdc_hs_tx.sv
// Directed bench for cdc_hs_tx (STATE=2): transfers, stale ack, timeout and reset.

module tb_cdc_hs_tx;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        valid;
   logic        ready;
   logic [31:0] dat_in;
   logic [31:0] dat_out;
   logic        req;
   logic        ack;
   logic        done;
   logic [15:0] tmo;
   logic        tmo_flag;
   logic        clr;

   int total = 0;
   int bad   = 0;

   cdc_hs_tx #(.DATA_WIDTH(32), .STATE(2), .TO_WIDTH(16)) dut (
      .clk_i     (clk),
      .rst_n_i   (rst_n),
      .valid_i   (valid),
      .ready_o   (ready),
      .dat_i     (dat_in),
      .dat_o     (dat_out),
      .req_o     (req),
      .ack_i     (ack),
      .done_o    (done),
      .timeout_i (tmo),
      .timeout_o (tmo_flag),
      .clr_i     (clr)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      int n_acc, n_done, viol, seen;
      logic acc;

      rst_n = 1'b0; valid = 1'b0; dat_in = '0; ack = 1'b0; tmo = '0; clr = 1'b0;
      #12;
      chk("rst_req", 32'(req), 32'd0);
      chk("rst_dat", dat_out, 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_tmo", 32'(tmo_flag), 32'd0);
      chk("rst_ready", 32'(ready), 32'd1);
      rst_n = 1'b1;
      tick();

      // Basic transfer
      valid = 1'b1; dat_in = 32'hA5A5_0001;
      tick();
      valid = 1'b0; dat_in = 32'hDEAD_BEEF;
      chk("b_req_up", 32'(req), 32'd1);
      chk("b_dat", dat_out, 32'hA5A5_0001);
      chk("b_ready_lo", 32'(ready), 32'd0);
      tick(); tick(); tick();
      ack = 1'b1;
      tick(); tick();
      chk("b_req_hold", 32'(req), 32'd1);
      tick();
      chk("b_req_drop", 32'(req), 32'd0);
      chk("b_dat_held", dat_out, 32'hA5A5_0001);
      ack = 1'b0;
      tick(); tick();
      chk("b_done_early", 32'(done), 32'd0);
      tick();
      chk("b_done", 32'(done), 32'd1);
      chk("b_ready_up", 32'(ready), 32'd1);
      tick();
      chk("b_done_once", 32'(done), 32'd0);

      // Back-to-back with an immediate-ack destination
      n_acc = 0; n_done = 0; viol = 0;
      valid = 1'b1; dat_in = 32'h1;
      for (int c = 0; c < 80; c++) begin
         acc = ready && valid;
         tick();
         ack = req;
         if (ready && req) viol++;
         if (done) n_done++;
         if (acc) begin
            n_acc++;
            if (n_acc == 1) begin
               chk("bb_dat1", dat_out, 32'h1);
               dat_in = 32'h2;
            end else begin
               chk("bb_dat2", dat_out, 32'h2);
               valid = 1'b0;
            end
         end
      end
      chk("bb_acc", 32'(n_acc), 32'd2);
      chk("bb_done", 32'(n_done), 32'd2);
      chk("bb_viol", 32'(viol), 32'd0);
      ack = 1'b0;
      tick(); tick(); tick(); tick();

      // Stale ack after reset
      rst_n = 1'b0; ack = 1'b1;
      #3;
      rst_n = 1'b1;
      tick(); tick(); tick();
      chk("st_ready0", 32'(ready), 32'd0);
      valid = 1'b1; dat_in = 32'h0000_0077;
      tick(); tick(); tick();
      chk("st_ready1", 32'(ready), 32'd0);
      chk("st_req", 32'(req), 32'd0);
      ack = 1'b0;
      tick();
      chk("st_ready2", 32'(ready), 32'd0);
      tick();
      chk("st_ready3", 32'(ready), 32'd1);
      tick();
      valid = 1'b0;
      chk("st_req_up", 32'(req), 32'd1);
      chk("st_dat", dat_out, 32'h0000_0077);
      ack = 1'b1;
      seen = 0;
      for (int c = 0; c < 20 && req; c++) tick();
      chk("st_req_drop", 32'(req), 32'd0);
      ack = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin tick(); if (done) seen = 1; end
      chk("st_done", 32'(seen), 32'd1);

      // Timeout
      tmo = 16'd5;
      valid = 1'b1; dat_in = 32'h55;
      tick();
      valid = 1'b0;
      tick(); tick(); tick(); tick();
      chk("to_before", 32'(tmo_flag), 32'd0);
      tick();
      chk("to_set", 32'(tmo_flag), 32'd1);
      chk("to_req", 32'(req), 32'd1);
      tick(); tick(); tick();
      chk("to_sticky", 32'(tmo_flag), 32'd1);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk("to_clr", 32'(tmo_flag), 32'd0);
      chk("to_req2", 32'(req), 32'd1);
      ack = 1'b1;
      for (int c = 0; c < 20 && req; c++) tick();
      chk("to_req_drop", 32'(req), 32'd0);
      ack = 1'b0;
      seen = 0;
      for (int c = 0; c < 20 && !seen; c++) begin tick(); if (done) seen = 1; end
      chk("to_done", 32'(seen), 32'd1);
      chk("to_flag_end", 32'(tmo_flag), 32'd0);

      // Timeout disabled, long wait
      tmo = 16'd0;
      valid = 1'b1; dat_in = 32'h66;
      tick();
      valid = 1'b0;
      seen = 0;
      for (int c = 0; c < 1000; c++) begin tick(); if (tmo_flag) seen = 1; end
      chk("nt_flag", 32'(seen), 32'd0);
      chk("nt_req", 32'(req), 32'd1);
      ack = 1'b1;
      for (int c = 0; c < 20 && req; c++) tick();
      chk("nt_req_drop", 32'(req), 32'd0);
      ack = 1'b0;
      seen = 0;
      for (int c = 0; c < 20 && !seen; c++) begin tick(); if (done) seen = 1; end
      chk("nt_done", 32'(seen), 32'd1);

      // Reset mid-REQ
      tmo = 16'd3;
      valid = 1'b1; dat_in = 32'h99;
      tick();
      valid = 1'b0;
      tick(); tick(); tick(); tick();
      chk("rm_req", 32'(req), 32'd1);
      chk("rm_tmo", 32'(tmo_flag), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rm_req0", 32'(req), 32'd0);
      chk("rm_dat0", dat_out, 32'd0);
      chk("rm_tmo0", 32'(tmo_flag), 32'd0);
      rst_n = 1'b1;
      tick();
      chk("rm_ready", 32'(ready), 32'd1);
      chk("rm_req_idle", 32'(req), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
